if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the single-issue pipelined CPU. Holds the program counter, drives the word address of the combinational instruction memory, and latches the returned instruction word into the IF/ID pipeline register. Accepts stall, redirect (branch/jump) and halt/resume controls from later pipeline stages.

## Interface

- `ADDR_WIDTH`, 10: instruction memory word-address width; the memory holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: instruction word width.
- `RESET_PC`, 32'h0000_0000: byte address loaded into the PC at reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  ADDR_WIDTH  word address to instruction memory; equals `pc[ADDR_WIDTH+1:2]`.
- `imem_data`  in  DATA_WIDTH  instruction word from memory; combinational in `imem_addr`.
- `stall`  in  1  hold the PC and IF/ID contents (load-use hazard).
- `redirect`  in  1  load the PC from `redirect_pc` and flush IF/ID.
- `redirect_pc`  in  32  branch or jump target byte address.
- `halt`  in  1  one-cycle pulse from decode on a halt syscall.
- `go`  in  1  resume pulse from the front-panel button (already debounced).
- `pc`  out  32  current PC, byte address.
- `if_id_ir`  out  DATA_WIDTH  latched instruction.
- `if_id_pc4`  out  32  PC+4 of the latched instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `halted`  out  1  the stage is in the HALTED state.
- `fetch_count`  out  32  count of instructions latched valid.

## Operation

- There are two states, RUN and HALTED. `halted` is 1 exactly while the state is HALTED.
- Reset is asynchronous and immediate on `rst_n`=0, including mid-operation:
  - `pc`=RESET_PC, state=RUN.
  - `if_id_ir`=0, `if_id_pc4`=0, `if_id_valid`=0, `fetch_count`=0.
- RUN, per-edge priority, highest first:
  1. `redirect`: `pc` <= {`redirect_pc`[31:2], 2'b00}. `if_id_valid` <= 0; `if_id_ir` and `if_id_pc4` are held. If `halt` is also high, the next state is HALTED, else RUN.
  2. `halt`: next state is HALTED. `pc` is held, `if_id_valid` <= 0.
  3. `stall`: `pc`, `if_id_ir`, `if_id_pc4` and `if_id_valid` are all held.
  4. Otherwise:
     - `if_id_ir` <= `imem_data`, `if_id_pc4` <= `pc`+4, `if_id_valid` <= 1.
     - `pc` <= `pc`+4.
     - `fetch_count` <= `fetch_count`+1.
- HALTED:
  - `redirect`, `stall` and `halt` are ignored. `pc` and the IF/ID register are held, with `if_id_valid`=0.
  - `go`=1: next state is RUN. Fetch resumes from the held `pc` on the following edge.
- Arithmetic:
  - `pc`+4 wraps modulo 2^32.
  - `imem_addr` ignores `pc` bits above ADDR_WIDTH+1, so fetch wraps modulo 2^ADDR_WIDTH words.
  - `fetch_count` wraps modulo 2^32.
- `go` in RUN has no effect.

## Timing

- `imem_addr` is combinational from `pc`. The instruction at `pc` appears in `if_id_ir` after one edge, so IF latency is 1 cycle.
- After `rst_n` deasserts:
  - the 1st edge latches mem[RESET_PC/4] with `if_id_valid`=1 and moves `pc` to RESET_PC+4;
  - sustained throughput is 1 instruction per cycle.
- Redirect penalty: the edge that takes the redirect leaves a bubble (`if_id_valid`=0). The target instruction is valid after the next edge.
- `halt` edge: `halted` goes to 1 and `if_id_valid` goes to 0 at the same edge.
- `go` edge: `halted` goes to 0. The first valid instruction appears one edge later.
- All outputs are registered except `imem_addr`.

## Test plan

- Reset then free-run: memory holds word k = 32'h1000_0000+k; release `rst_n` with no stalls. After edge n: `if_id_ir`=32'h1000_0000+(n-1), `if_id_pc4`=4n, `pc`=4n, `fetch_count`=n.
- Stall: at `pc`=8, assert `stall` for 3 cycles. `pc` stays 8 and `if_id_ir` holds word 1 throughout. On release, word 2 latches on the next edge and `fetch_count` skips no value.
- Redirect with stall, misaligned target: at `pc`=12, assert `redirect`=1 with `redirect_pc`=32'h0000_0043 and `stall`=1. Next `pc`=32'h40 and `if_id_valid`=0. The following edge latches word 16 with `if_id_pc4`=32'h44.
- Halt/resume: pulse `halt` at `pc`=20. `halted`=1, `pc` stays 20, `if_id_valid`=0. Redirect and stall are ignored while halted. Pulse `go`; one cycle later word 5 latches valid.
- Wrap: set `redirect_pc`=32'h0000_0FFC with ADDR_WIDTH=10. Word 1023 latches. Next `pc`=32'h1000 gives `imem_addr`=0.
- Async reset mid-run: drop `rst_n` between edges. All outputs take their reset values immediately, before the next edge.

Source files
------------

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory port, pipeline controls and IF/ID outputs.
interface if_stage_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  stall;
  logic                  redirect;
  logic [31:0]           redirect_pc;
  logic                  halt;
  logic                  go;
  logic [31:0]           pc;
  logic [DATA_WIDTH-1:0] if_id_ir;
  logic [31:0]           if_id_pc4;
  logic                  if_id_valid;
  logic                  halted;
  logic [31:0]           fetch_count;

  modport slave (
    input  imem_data, stall, redirect, redirect_pc, halt, go,
    output imem_addr, pc, if_id_ir, if_id_pc4, if_id_valid, halted, fetch_count
  );

  modport master (
    output imem_data, stall, redirect, redirect_pc, halt, go,
    input  imem_addr, pc, if_id_ir, if_id_pc4, if_id_valid, halted, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction memory addressing and IF/ID latch,
// with redirect/halt/stall control and a RUN/HALTED state machine.
module if_stage #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.slave   bus
);

  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0]   pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic [31:0]           count_q, count_d;
  logic [PC_WIDTH-1:0]   pc_plus4;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  // State and pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state: redirect > halt > stall > fetch while running
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
          valid_d = 1'b0;
          if (bus.halt) state_d = ST_HALTED;
        end else if (bus.halt) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          ir_d    = bus.imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          count_d = count_q + 32'(1);
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
        if (bus.go) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.imem_addr   = pc_q[ADDR_WIDTH+1:2];
  assign bus.pc          = pc_q;
  assign bus.if_id_ir    = ir_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations,
// then randomized control traffic compared every cycle against a behavioural model.
module tb_if_stage;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  if_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem [WORDS];
  assign bus.imem_data = mem[bus.imem_addr];

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_ir, m_pc4, m_cnt;
  bit          m_valid, m_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      if (bus.go) m_halted = 1'b0;
    end else if (bus.redirect) begin
      m_pc     = bus.redirect_pc - (bus.redirect_pc % 4);
      m_valid  = 1'b0;
      m_halted = bus.halt;
    end else if (bus.halt) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (!bus.stall) begin
      m_ir    = mem[(m_pc / 4) % WORDS];
      m_pc4   = m_pc + 4;
      m_pc    = m_pc + 4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc",          bus.pc,                        m_pc);
      chk("imem_addr",   32'(bus.imem_addr),            (m_pc / 4) % WORDS);
      chk("if_id_valid", 32'(bus.if_id_valid),          32'(m_valid));
      chk("halted",      32'(bus.halted),               32'(m_halted));
      chk("fetch_count", bus.fetch_count,               m_cnt);
      chk("if_id_ir",    bus.if_id_ir,                  m_ir);
      chk("if_id_pc4",   bus.if_id_pc4,                 m_pc4);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0; bus.go = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) mem[k] = 32'h1000_0000 + 32'(k);
    rst_n = 1'b0;
    bus.redirect_pc = 32'h0;
    idle();
    cyc();
    cmp_en = 1'b1;
    cyc();
    chk("rst_pc",    bus.pc, 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_count", bus.fetch_count, 32'h0);
    chk("rst_halt",  32'(bus.halted), 32'h0);
    rst_n = 1'b1;

    // Free run: two edges
    for (int n = 1; n <= 2; n++) begin
      cyc();
      chk("run_ir",  bus.if_id_ir, 32'h1000_0000 + 32'(n - 1));
      chk("run_pc4", bus.if_id_pc4, 32'(4 * n));
      chk("run_pc",  bus.pc, 32'(4 * n));
      chk("run_cnt", bus.fetch_count, 32'(n));
    end

    // Stall at pc=8
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", bus.pc, 32'h8);
      chk("stall_ir", bus.if_id_ir, 32'h1000_0001);
    end
    bus.stall = 1'b0;
    cyc();
    chk("unstall_ir",  bus.if_id_ir, 32'h1000_0002);
    chk("unstall_cnt", bus.fetch_count, 32'h3);

    // Misaligned redirect with concurrent stall at pc=12
    chk("pre_redir_pc", bus.pc, 32'hC);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h43; bus.stall = 1'b1;
    cyc();
    idle();
    chk("redir_pc",    bus.pc, 32'h40);
    chk("redir_valid", 32'(bus.if_id_valid), 32'h0);
    cyc();
    chk("tgt_ir",    bus.if_id_ir, 32'h1000_0010);
    chk("tgt_pc4",   bus.if_id_pc4, 32'h44);
    chk("tgt_valid", 32'(bus.if_id_valid), 32'h1);

    // Halt at pc=20, ignored controls, resume
    bus.redirect = 1'b1; bus.redirect_pc = 32'h14;
    cyc();
    idle();
    bus.halt = 1'b1;
    cyc();
    idle();
    chk("halt_flag",  32'(bus.halted), 32'h1);
    chk("halt_pc",    bus.pc, 32'h14);
    chk("halt_valid", 32'(bus.if_id_valid), 32'h0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.stall = 1'b1;
    repeat (2) cyc();
    chk("halt_ign_pc", bus.pc, 32'h14);
    idle();
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    chk("go_flag",  32'(bus.halted), 32'h0);
    chk("go_valid", 32'(bus.if_id_valid), 32'h0);
    cyc();
    chk("resume_ir",    bus.if_id_ir, 32'h1000_0005);
    chk("resume_valid", 32'(bus.if_id_valid), 32'h1);

    // Memory wrap at the top word
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0FFC;
    cyc();
    idle();
    cyc();
    chk("wrap_ir",   bus.if_id_ir, 32'h1000_03FF);
    chk("wrap_pc",   bus.pc, 32'h1000);
    chk("wrap_addr", 32'(bus.imem_addr), 32'h0);

    // PC wraps modulo 2^32
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    idle();
    cyc();
    chk("pcwrap_pc",  bus.pc, 32'h0);
    chk("pcwrap_pc4", bus.if_id_pc4, 32'h0);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc",    bus.pc, 32'h0);
    chk("arst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("arst_count", bus.fetch_count, 32'h0);
    chk("arst_ir",    bus.if_id_ir, 32'h0);
    chk("arst_pc4",   bus.if_id_pc4, 32'h0);
    cyc();
    rst_n = 1'b1;

    // Randomized control traffic
    for (int k = 0; k < WORDS; k++) mem[k] = $urandom;
    repeat (2000) begin
      cyc();
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      bus.redirect    = ($urandom_range(0, 9) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191));
      bus.halt        = ($urandom_range(0, 19) == 0);
      bus.stall       = ($urandom_range(0, 4) == 0);
      bus.go          = ($urandom_range(0, 6) == 0);
    end
    idle();
    cyc();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
